video_in_burst_ctrl: RTL and testbench

VIDEO_IN_BURST_CTRL -- requirements
Module: video_in_burst_ctrl

---
 rtl/video_in_burst_ctrl_if.sv | 27 ++
 rtl/video_in_burst_ctrl.sv | 99 +++++++++
 tb/tb_video_in_burst_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/video_in_burst_ctrl_if.sv
// video_in_burst_ctrl_if: processor address strobe, pixel FIFO read side and Wishbone B3 master bus
// master: the burst controller; slave: the processor/FIFO/Wishbone environment around it
interface video_in_burst_ctrl_if;
  logic [31:0] addr_in;
  logic        addr_valid;
  logic        new_addr;
  logic [5:0]  fifo_level;
  logic [31:0] fifo_rdata;
  logic        fifo_re;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic        wb_ack;
  logic        frame_done;
  modport master (
    input  addr_in, addr_valid, fifo_level, fifo_rdata, wb_ack,
    output new_addr, fifo_re, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel, wb_cti, frame_done
  );
  modport slave (
    output addr_in, addr_valid, fifo_level, fifo_rdata, wb_ack,
    input  new_addr, fifo_re, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel, wb_cti, frame_done
  );
endinterface

// File: rtl/video_in_burst_ctrl.sv
// video_in_burst_ctrl: moves captured pixel words from a show-ahead FIFO into a frame buffer with fixed-length Wishbone write bursts
// ports: clk, RST (sync active-high), bus (master modport: address strobe in, new_addr/frame_done pulses out, FIFO pop, Wishbone master)
module video_in_burst_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int BURST  = 16
) (
  input logic                    clk,
  input logic                    RST,
  video_in_burst_ctrl_if.master  bus
);
  localparam int         FRAME_WORDS = WIDTH * HEIGHT / 4;
  localparam logic [16:0] FW_LAST    = 17'(FRAME_WORDS - 1);
  localparam logic [5:0]  LEVEL      = 6'(BURST);
  localparam logic [5:0]  LAST       = 6'(BURST - 1);
  localparam logic [5:0]  PENULT     = 6'(BURST - 2);
  localparam logic [2:0]  CTI_FIRST  = (BURST == 1) ? 3'b111 : 3'b010;
  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;
  state_t      state_q;
  logic        pend_v_q, new_addr_q, frame_done_q, cyc_q;
  logic [31:0] pend_addr_q, cur_base_q, adr_q;
  logic [16:0] word_cnt_q;
  logic [5:0]  burst_cnt_q;
  logic [2:0]  cti_q;
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      pend_v_q     <= 1'b0;
      pend_addr_q  <= '0;
      cur_base_q   <= '0;
      word_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      cyc_q        <= 1'b0;
      cti_q        <= '0;
      adr_q        <= '0;
      new_addr_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      new_addr_q   <= bus.addr_valid;
      frame_done_q <= 1'b0;
      if (bus.addr_valid) begin
        pend_addr_q <= bus.addr_in;
        pend_v_q    <= 1'b1;
      end
      case (state_q)
        IDLE: if (pend_v_q) begin
          cur_base_q <= pend_addr_q;
          pend_v_q   <= bus.addr_valid;
          word_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: if (bus.fifo_level >= LEVEL) begin
          burst_cnt_q <= '0;
          cyc_q       <= 1'b1;
          cti_q       <= CTI_FIRST;
          adr_q       <= cur_base_q + {13'd0, word_cnt_q, 2'b00};
          state_q     <= XFER;
        end
        XFER: if (bus.wb_ack) begin
          word_cnt_q  <= word_cnt_q + 17'd1;
          burst_cnt_q <= burst_cnt_q + 6'd1;
          adr_q       <= adr_q + 32'd4;
          if (burst_cnt_q == PENULT) cti_q <= 3'b111;
          if (burst_cnt_q == LAST) begin
            cyc_q       <= 1'b0;
            cti_q       <= '0;
            adr_q       <= '0;
            burst_cnt_q <= '0;
            state_q     <= WAIT;
            // frame end: an address arriving on this very cycle beats the older pending one
            if (word_cnt_q == FW_LAST) begin
              frame_done_q <= 1'b1;
              word_cnt_q   <= '0;
              if (bus.addr_valid) begin
                cur_base_q <= bus.addr_in;
                pend_v_q   <= 1'b0;
              end else if (pend_v_q) begin
                cur_base_q <= pend_addr_q;
                pend_v_q   <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.new_addr   = new_addr_q;
  assign bus.frame_done = frame_done_q;
  assign bus.wb_cyc     = cyc_q;
  assign bus.wb_stb     = cyc_q;
  assign bus.wb_we      = cyc_q;
  assign bus.wb_adr     = adr_q;
  assign bus.wb_cti     = cti_q;
  assign bus.wb_sel     = cyc_q ? 4'hF : 4'h0;
  // show-ahead FIFO head tracks each pop, so data is passed straight through rather than registered
  assign bus.wb_dat_o   = cyc_q ? bus.fifo_rdata : 32'd0;
  assign bus.fifo_re    = bus.wb_ack & cyc_q;
endmodule

// File: tb/tb_video_in_burst_ctrl.sv
// tb_video_in_burst_ctrl: directed self-checking bench, 32-word frames (two bursts) to keep runs short
module tb_video_in_burst_ctrl;
  logic clk = 1'b0;
  logic RST = 1'b1;
  int errors = 0;
  int checks = 0;
  int npop = 0;
  logic [31:0] pops = 32'd0;
  video_in_burst_ctrl_if bus ();
  video_in_burst_ctrl #(.WIDTH(16), .HEIGHT(8), .BURST(16)) dut (.clk(clk), .RST(RST), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.fifo_re) pops <= pops + 32'd1;
  assign bus.fifo_rdata = 32'hD000_0000 + pops;
  function automatic logic [31:0] pat(input int n);
    return 32'hD000_0000 + 32'(n);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic burst(input logic [31:0] a0, input int stall_at, input int av_at, input logic [31:0] av_addr);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        bus.wb_ack = 1'b0;
        repeat (3) begin
          step();
          chk("stall_cyc", bus.wb_cyc, 1);
          chk("stall_adr", bus.wb_adr, a0 + 32'(4 * i));
          chk("stall_dat", bus.wb_dat_o, pat(npop));
          chk("stall_re", bus.fifo_re, 0);
        end
        bus.wb_ack = 1'b1;
        #1;
      end
      chk("beat_cyc", bus.wb_cyc, 1);
      chk("beat_adr", bus.wb_adr, a0 + 32'(4 * i));
      chk("beat_cti", bus.wb_cti, (i == 15) ? 3'b111 : 3'b010);
      chk("beat_dat", bus.wb_dat_o, pat(npop));
      chk("beat_re", bus.fifo_re, 1);
      if (i == av_at) begin
        bus.addr_in = av_addr;
        bus.addr_valid = 1'b1;
      end
      step();
      npop++;
      if (bus.addr_valid) begin
        chk("av_new_addr", bus.new_addr, 1);
        bus.addr_valid = 1'b0;
      end
    end
  endtask
  initial begin
    bus.addr_in = 32'd0;
    bus.addr_valid = 1'b0;
    bus.fifo_level = 6'd0;
    bus.wb_ack = 1'b0;
    repeat (3) step();
    chk("rst_cyc", bus.wb_cyc, 0);
    chk("rst_cti", bus.wb_cti, 0);
    chk("rst_adr", bus.wb_adr, 0);
    chk("rst_sel", bus.wb_sel, 0);
    chk("rst_dat", bus.wb_dat_o, 0);
    chk("rst_new_addr", bus.new_addr, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    RST = 1'b0;
    bus.fifo_level = 6'd16;
    repeat (3) begin
      step();
      chk("noaddr_cyc", bus.wb_cyc, 0);
    end
    bus.addr_in = 32'h1000_0000;
    bus.addr_valid = 1'b1;
    bus.wb_ack = 1'b1;
    step();
    chk("new_addr_pulse", bus.new_addr, 1);
    chk("pre_cyc", bus.wb_cyc, 0);
    bus.addr_valid = 1'b0;
    step();
    chk("new_addr_low", bus.new_addr, 0);
    chk("wait_cyc", bus.wb_cyc, 0);
    step();
    burst(32'h1000_0000, -1, -1, 32'd0);
    chk("b0_end_cyc", bus.wb_cyc, 0);
    chk("b0_end_cti", bus.wb_cti, 0);
    chk("b0_no_done", bus.frame_done, 0);
    bus.fifo_level = 6'd15;
    repeat (3) begin
      step();
      chk("lvl15_cyc", bus.wb_cyc, 0);
      chk("lvl15_re", bus.fifo_re, 0);
    end
    bus.fifo_level = 6'd16;
    step();
    burst(32'h1000_0040, 3, 5, 32'h2000_0000);
    chk("f0_done", bus.frame_done, 1);
    chk("f0_end_cyc", bus.wb_cyc, 0);
    step();
    chk("f0_done_once", bus.frame_done, 0);
    burst(32'h2000_0000, -1, -1, 32'd0);
    step();
    burst(32'h2000_0040, -1, -1, 32'd0);
    chk("f1_done", bus.frame_done, 1);
    step();
    burst(32'h2000_0000, -1, -1, 32'd0);
    step();
    burst(32'h2000_0040, -1, 15, 32'h3000_0000);
    chk("f2_done", bus.frame_done, 1);
    step();
    chk("f3_cyc", bus.wb_cyc, 1);
    chk("f3_adr", bus.wb_adr, 32'h3000_0000);
    for (int i = 0; i < 7; i++) begin
      chk("pre_rst_adr", bus.wb_adr, 32'h3000_0000 + 32'(4 * i));
      chk("pre_rst_dat", bus.wb_dat_o, pat(npop));
      step();
      npop++;
    end
    chk("beat7_adr", bus.wb_adr, 32'h3000_001C);
    RST = 1'b1;
    step();
    npop++;
    chk("midrst_cyc", bus.wb_cyc, 0);
    chk("midrst_re", bus.fifo_re, 0);
    chk("midrst_cti", bus.wb_cti, 0);
    chk("midrst_adr", bus.wb_adr, 0);
    RST = 1'b0;
    repeat (4) begin
      step();
      chk("postrst_cyc", bus.wb_cyc, 0);
      chk("postrst_re", bus.fifo_re, 0);
    end
    bus.addr_in = 32'h4000_0000;
    bus.addr_valid = 1'b1;
    step();
    chk("postrst_new_addr", bus.new_addr, 1);
    bus.addr_valid = 1'b0;
    step();
    chk("postrst_wait_cyc", bus.wb_cyc, 0);
    step();
    chk("postrst_cyc_on", bus.wb_cyc, 1);
    chk("postrst_adr", bus.wb_adr, 32'h4000_0000);
    chk("postrst_cti", bus.wb_cti, 3'b010);
    chk("postrst_dat", bus.wb_dat_o, pat(npop));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
